stabilizer_row_writer: RTL

- Producer/sequencer at the write end of the stabilizer register array. Accepts stabilizer rows (literals plus phase vector) from an upstream generator over a valid/ready handshake and emits registered shift-down load commands, one per row, until num_qubit rows have been pushed.
- Also forwards a cofactor position to the array's cofactor register.
- Signals completion so the downstream row processor can begin consuming the bottom row.

---
 rtl/stabilizer_row_writer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/stabilizer_row_writer.sv
// Write-end sequencer for the stabilizer array: accepts num_qubit rows and issues shift-down loads.
// Define ROW_WRITER_ROTATE_EN to add rotate_amt and a post-load literal rotation phase.
module stabilizer_row_writer #(
  parameter int num_qubit  = 4,
  parameter int max_vector = 2 ** num_qubit
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               row_valid,
  output logic                               row_ready,
  input  logic [num_qubit-1:0][1:0]          row_literals,
  input  logic [max_vector-1:0]              row_phase,
  input  logic                               cofactor_valid,
  input  logic [31:0]                        cofactor_pos,
`ifdef ROW_WRITER_ROTATE_EN
  input  logic [$clog2(num_qubit)-1:0]       rotate_amt,
`endif
  output logic                               ld_reg,
  output logic [1:0]                         shift_rotate_array,
  output logic [num_qubit-1:0][1:0]          literals_in,
  output logic [max_vector-1:0]              phase_in,
  output logic                               ld_cofactor_info,
  output logic [31:0]                        cofactor_pos_out,
  output logic [$clog2(num_qubit+1)-1:0]     row_count,
  output logic                               busy,
  output logic                               done
);

  localparam int CNT_W = $clog2(num_qubit + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(num_qubit - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_ROTATE, S_DONE} state_t;

  state_t                      r_state;
  logic                        r_ld_reg;
  logic [num_qubit-1:0][1:0]   r_literals;
  logic [max_vector-1:0]       r_phase;
  logic                        r_ld_cof;
  logic [31:0]                 r_cof_pos;
  logic [CNT_W-1:0]            r_row_count;
  logic                        r_busy;
  logic                        r_done;
`ifdef ROW_WRITER_ROTATE_EN
  localparam int ROT_W = $clog2(num_qubit);
  logic                        r_rotate;
  logic [ROT_W-1:0]            r_rot_amt;
  logic [ROT_W-1:0]            r_rot_left;
`endif

  // Abort wins over a pending handshake, so it also gates the ready.
  assign row_ready = (r_state == S_LOAD) & ~abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ld_reg    <= 1'b0;
      r_literals  <= '0;
      r_phase     <= '0;
      r_ld_cof    <= 1'b0;
      r_cof_pos   <= '0;
      r_row_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef ROW_WRITER_ROTATE_EN
      r_rotate    <= 1'b0;
      r_rot_amt   <= '0;
      r_rot_left  <= '0;
`endif
    end else begin
      r_ld_cof <= cofactor_valid;
      if (cofactor_valid) r_cof_pos <= cofactor_pos;
      r_ld_reg <= 1'b0;
      r_done   <= 1'b0;
`ifdef ROW_WRITER_ROTATE_EN
      r_rotate <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state     <= S_LOAD;
            r_busy      <= 1'b1;
            r_row_count <= '0;
`ifdef ROW_WRITER_ROTATE_EN
            r_rot_amt   <= rotate_amt;
`endif
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (row_valid) begin
            r_literals  <= row_literals;
            r_phase     <= row_phase;
            r_ld_reg    <= 1'b1;
            r_row_count <= r_row_count + 1'b1;
            if (r_row_count == LAST_ROW) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
`ifdef ROW_WRITER_ROTATE_EN
          else if (r_rot_amt != '0) begin
            r_state    <= S_ROTATE;
            r_ld_reg   <= 1'b1;
            r_rotate   <= 1'b1;
            r_rot_left <= r_rot_amt;
          end
`endif
          else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
`ifdef ROW_WRITER_ROTATE_EN
        S_ROTATE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_rot_left == ROT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_ld_reg   <= 1'b1;
            r_rotate   <= 1'b1;
            r_rot_left <= r_rot_left - 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ld_reg           = r_ld_reg;
  assign literals_in      = r_literals;
  assign phase_in         = r_phase;
  assign ld_cofactor_info = r_ld_cof;
  assign cofactor_pos_out = r_cof_pos;
  assign row_count        = r_row_count;
  assign busy             = r_busy;
  assign done             = r_done;
`ifdef ROW_WRITER_ROTATE_EN
  assign shift_rotate_array = {1'b0, r_rotate};
`else
  assign shift_rotate_array = 2'b00;
`endif

endmodule
